// File: rtl/dmac_multi_pkg.sv
// dmac_multi_pkg: shared states, AHB encodings and config field positions for the multi-channel DMAC.
package dmac_multi_pkg;
  typedef enum logic [3:0] {IDLE, ARB, BUSREQ, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, NEXT, DONE} state_t;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] SEL_SRC = 2'd0;
  localparam logic [1:0] SEL_DST = 2'd1;
  localparam logic [1:0] SEL_CNT = 2'd2;
  localparam logic [1:0] SEL_CTRL = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_SRC_INC = 1;
  localparam int CTRL_DST_INC = 2;
endpackage

// File: rtl/dmac_multi_channel_if.sv
// dmac_multi_channel_if: system-bus request/grant plus AHB-lite master signals.
interface dmac_multi_channel_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic Bus_Req;
  logic Bus_Grant;
  logic [ADDR_W-1:0] MAddress;
  logic [DATA_W-1:0] MWData;
  logic [DATA_W-1:0] MRData;
  logic MWrite;
  logic [1:0] MTrans;
  logic [DATA_W/8-1:0] MWStrb;
  logic HReady;
  logic [1:0] M_HResp;
  modport master (
    output Bus_Req, MAddress, MWData, MWrite, MTrans, MWStrb,
    input Bus_Grant, MRData, HReady, M_HResp
  );
  modport slave (
    input Bus_Req, MAddress, MWData, MWrite, MTrans, MWStrb,
    output Bus_Grant, MRData, HReady, M_HResp
  );
endinterface

// File: rtl/dmac_rr_arbiter.sv
// dmac_rr_arbiter: picks the first requester after the last-served index, wrapping around.
module dmac_rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [$clog2(NCH)-1:0] last,
  output logic [$clog2(NCH)-1:0] gnt,
  output logic valid
);
  localparam int CW = $clog2(NCH);
  // scan from farthest to nearest so the nearest requester after last wins
  always_comb begin
    gnt = last;
    for (int i = NCH; i >= 1; i--)
      if (req[CW'((int'(last) + i) % NCH)]) gnt = CW'((int'(last) + i) % NCH);
  end
  assign valid = |req;
endmodule

// File: rtl/dmac_multi_channel.sv
// dmac_multi_channel: NCH-channel DMA engine sharing one AHB-lite master, one word read then write per element.
// Define DMAC_ERR_ABORT_EN to abort a channel on HRESP=ERROR and expose err_status.
module dmac_multi_channel
  import dmac_multi_pkg::*;
#(
  parameter int NCH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter int BEATS_PER_GRANT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic [NCH-1:0] DmacReq,
  output logic [NCH-1:0] ReqAck,
  dmac_multi_channel_if.master bus,
  input  logic cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [1:0] cfg_sel,
  input  logic [ADDR_W-1:0] cfg_wdata,
  input  logic [NCH-1:0] irq_clr,
  output logic [NCH-1:0] irq_status,
`ifdef DMAC_ERR_ABORT_EN
  output logic [NCH-1:0] err_status,
`endif
  output logic Interrupt
);
  localparam int CW = $clog2(NCH);
  localparam int BW = $clog2(BEATS_PER_GRANT + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
  state_t state;
  logic [ADDR_W-1:0] src [NCH];
  logic [ADDR_W-1:0] dst [NCH];
  logic [CNT_W-1:0] cnt [NCH];
  logic [2:0] ctrl [NCH];
  logic [CW-1:0] ch, last, gnt, act_ch;
  logic [BW-1:0] beat;
  logic [DATA_W-1:0] data;
  logic [NCH-1:0] elig;
  logic gnt_v, cfg_ok, abort;
  dmac_rr_arbiter #(.NCH(NCH)) u_arb (.req(elig), .last(last), .gnt(gnt), .valid(gnt_v));
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) elig[i] = DmacReq[i] & ctrl[i][CTRL_EN];
  end
  // in ARB the channel about to be latched is already protected from config writes
  assign act_ch = (state == ARB) ? gnt : ch;
  assign cfg_ok = cfg_we && (state == IDLE || cfg_ch != act_ch);
`ifdef DMAC_ERR_ABORT_EN
  assign abort = bus.M_HResp == HRESP_ERROR;
`else
  assign abort = 1'b0;
`endif
  assign ReqAck = (state == DONE) ? (NCH'(1) << ch) : '0;
  assign Interrupt = |irq_status;
  assign bus.Bus_Req = state inside {BUSREQ, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, NEXT};
  assign bus.MTrans = (state == RD_ADDR || state == WR_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.MWrite = state == WR_ADDR;
  assign bus.MAddress = (state == RD_ADDR) ? src[ch] : (state == WR_ADDR) ? dst[ch] : '0;
  assign bus.MWData = (state == WR_DATA) ? data : '0;
  assign bus.MWStrb = {(DATA_W / 8){state == WR_DATA}};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      last <= '0;
      beat <= '0;
      data <= '0;
      irq_status <= '0;
`ifdef DMAC_ERR_ABORT_EN
      err_status <= '0;
`endif
      for (int i = 0; i < NCH; i++) begin
        src[i] <= '0;
        dst[i] <= '0;
        cnt[i] <= '0;
        ctrl[i] <= '0;
      end
    end else begin
      if (cfg_ok && cfg_sel == SEL_SRC) src[cfg_ch] <= cfg_wdata;
      if (cfg_ok && cfg_sel == SEL_DST) dst[cfg_ch] <= cfg_wdata;
      if (cfg_ok && cfg_sel == SEL_CNT) cnt[cfg_ch] <= cfg_wdata[CNT_W-1:0];
      if (cfg_ok && cfg_sel == SEL_CTRL) ctrl[cfg_ch] <= cfg_wdata[2:0];
      irq_status <= (irq_status & ~irq_clr) | ReqAck;
`ifdef DMAC_ERR_ABORT_EN
      // a normal completion always leaves count at zero, an abort freezes it non-zero
      err_status <= (err_status & ~irq_clr) | ((cnt[ch] != '0) ? ReqAck : '0);
`endif
      case (state)
        IDLE: state <= |elig ? ARB : IDLE;
        ARB: begin
          ch <= gnt;
          last <= gnt;
          beat <= '0;
          state <= !gnt_v ? IDLE : (cnt[gnt] == '0) ? DONE : BUSREQ;
        end
        BUSREQ: state <= bus.Bus_Grant ? RD_ADDR : BUSREQ;
        RD_ADDR: state <= bus.HReady ? RD_DATA : RD_ADDR;
        RD_DATA: begin
          if (bus.HReady) data <= bus.MRData;
          state <= abort ? DONE : bus.HReady ? WR_ADDR : RD_DATA;
        end
        WR_ADDR: state <= bus.HReady ? WR_DATA : WR_ADDR;
        WR_DATA: state <= abort ? DONE : bus.HReady ? NEXT : WR_DATA;
        NEXT: begin
          cnt[ch] <= cnt[ch] - CNT_W'(1);
          if (ctrl[ch][CTRL_SRC_INC]) src[ch] <= src[ch] + STEP;
          if (ctrl[ch][CTRL_DST_INC]) dst[ch] <= dst[ch] + STEP;
          beat <= beat + BW'(1);
          state <= (cnt[ch] == CNT_W'(1)) ? DONE :
                   (beat == BW'(BEATS_PER_GRANT - 1) || !DmacReq[ch]) ? IDLE : RD_ADDR;
        end
        DONE: begin
          ctrl[ch][CTRL_EN] <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmac_multi_channel.sv
// tb_dmac_multi_channel: directed bench with an AHB slave model that returns addr^K and can stall or error reads.
module tb_dmac_multi_channel;
  localparam logic [31:0] K = 32'hC0DE0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] ack;
  logic [3:0] irq_clr = '0;
  logic [3:0] irq_status;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [1:0] cfg_sel = '0;
  logic [31:0] cfg_wdata = '0;
  logic intr;
`ifdef DMAC_ERR_ABORT_EN
  logic [3:0] err_status;
`endif
  logic [1:0] hresp = 2'b00;
  int stall_rd = 0, stall_cnt = 0, err_at = -1, rd_num = 0, rd_seen = 0;
  logic [31:0] rd_addr_q = '0;
  logic [32:0] alog [$];
  logic [31:0] wlog [$];
  int nonseq_cnt = 0, breq_rise = 0;
  logic breq_q = 1'b0;
  int ack_cnt [4] = '{default: 0};
  int checks = 0, errors = 0;
  dmac_multi_channel_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  assign bus.Bus_Grant = bus.Bus_Req;
  assign bus.HReady = stall_cnt == 0;
  assign bus.MRData = bus.HReady ? (rd_addr_q ^ K) : 32'hBAD0BAD0;
  assign bus.M_HResp = hresp;
  dmac_multi_channel #(.NCH(4), .ADDR_W(32), .DATA_W(32), .CNT_W(16), .BEATS_PER_GRANT(4)) dut (
    .clk(clk), .rst(rst), .DmacReq(req), .ReqAck(ack), .bus(bus),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .irq_clr(irq_clr), .irq_status(irq_status),
`ifdef DMAC_ERR_ABORT_EN
    .err_status(err_status),
`endif
    .Interrupt(intr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.MTrans == 2'b10) nonseq_cnt++;
    if (bus.MTrans == 2'b10 && bus.HReady) begin
      alog.push_back({bus.MWrite, bus.MAddress});
      if (!bus.MWrite) begin
        rd_addr_q = bus.MAddress;
        rd_num++;
      end
    end
    if (bus.MWStrb == 4'hF && bus.HReady) wlog.push_back(bus.MWData);
    if (bus.Bus_Req && !breq_q) breq_rise++;
    breq_q = bus.Bus_Req;
    for (int i = 0; i < 4; i++) if (ack[i]) ack_cnt[i]++;
  end
  always @(posedge clk) begin
    if (rd_num != rd_seen) begin
      rd_seen <= rd_num;
      stall_cnt <= stall_rd;
      hresp <= (rd_num == err_at) ? 2'b01 : 2'b00;
    end else begin
      stall_cnt <= (stall_cnt > 0) ? stall_cnt - 1 : 0;
      hresp <= 2'b00;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cfg(input int c, input int s, input logic [31:0] d);
    cfg_we = 1'b1; cfg_ch = 2'(c); cfg_sel = 2'(s); cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask
  task automatic wait_ack(input int c, input int n, output bit ok);
    int t = 0;
    while (ack_cnt[c] < n && t < 500) begin @(posedge clk); #1; t++; end
    ok = ack_cnt[c] >= n;
  endtask
  task automatic test_reset();
    checks++; if (bus.Bus_Req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus.Bus_Req); end
    checks++; if (bus.MTrans !== 2'b00) begin errors++; $display("FAIL reset_mtrans: got %b want 00", bus.MTrans); end
    checks++; if (bus.MWStrb !== 4'h0) begin errors++; $display("FAIL reset_mwstrb: got %h want 0", bus.MWStrb); end
    checks++; if (bus.MAddress !== 32'h0) begin errors++; $display("FAIL reset_maddress: got %h want 0", bus.MAddress); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_reqack: got %b want 0000", ack); end
    checks++; if (irq_status !== 4'h0) begin errors++; $display("FAIL reset_irq: got %b want 0000", irq_status); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_interrupt: got %b want 0", intr); end
  endtask
  task automatic test_single();
    bit ok;
    int a0 = ack_cnt[0];
    alog.delete(); wlog.delete();
    cfg(0, 0, 32'h100); cfg(0, 1, 32'h200); cfg(0, 2, 32'd3); cfg(0, 3, 32'd7);
    req[0] = 1'b1;
    wait_ack(0, a0 + 1, ok);
    req[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL single_done: ReqAck[0] not seen, want pulse"); end
    checks++; if (alog.size() !== 6) begin errors++; $display("FAIL single_addr_count: got %0d want 6", alog.size()); end
    for (int i = 0; i < 3 && alog.size() == 6; i++) begin
      checks++; if (alog[2*i] !== {1'b0, 32'h100 + 32'(4*i)}) begin errors++; $display("FAIL single_rd%0d: got %h want %h", i, alog[2*i], {1'b0, 32'h100 + 32'(4*i)}); end
      checks++; if (alog[2*i+1] !== {1'b1, 32'h200 + 32'(4*i)}) begin errors++; $display("FAIL single_wr%0d: got %h want %h", i, alog[2*i+1], {1'b1, 32'h200 + 32'(4*i)}); end
    end
    checks++; if (wlog.size() !== 3) begin errors++; $display("FAIL single_wdata_count: got %0d want 3", wlog.size()); end
    for (int i = 0; i < 3 && wlog.size() == 3; i++) begin
      checks++; if (wlog[i] !== ((32'h100 + 32'(4*i)) ^ K)) begin errors++; $display("FAIL single_wdata%0d: got %h want %h", i, wlog[i], (32'h100 + 32'(4*i)) ^ K); end
    end
    checks++; if (ack_cnt[0] - a0 !== 1) begin errors++; $display("FAIL single_ack_width: got %0d ack cycles want 1", ack_cnt[0] - a0); end
    checks++; if (irq_status !== 4'b0001) begin errors++; $display("FAIL single_irq: got %b want 0001", irq_status); end
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL single_interrupt: got %b want 1", intr); end
    irq_clr = 4'hF;
    @(posedge clk); #1;
    irq_clr = 4'h0;
    checks++; if (irq_status !== 4'b0000) begin errors++; $display("FAIL irq_clear: got %b want 0000", irq_status); end
  endtask
  task automatic test_round_robin();
    bit ok1, ok2;
    int b0 = breq_rise;
    logic [31:0] rds [$];
    logic [31:0] exp_a;
    alog.delete();
    cfg(1, 0, 32'h1000); cfg(1, 1, 32'h3000); cfg(1, 2, 32'd8); cfg(1, 3, 32'd7);
    cfg(2, 0, 32'h2000); cfg(2, 1, 32'h4000); cfg(2, 2, 32'd8); cfg(2, 3, 32'd7);
    req = 4'b0110;
    wait_ack(1, ack_cnt[1] + 1, ok1);
    wait_ack(2, ack_cnt[2] + 1, ok2);
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    foreach (alog[i]) if (!alog[i][32]) rds.push_back(alog[i][31:0]);
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL rr_done: acks ch1=%0b ch2=%0b want 1 1", ok1, ok2); end
    checks++; if (rds.size() !== 16) begin errors++; $display("FAIL rr_read_count: got %0d want 16", rds.size()); end
    for (int t = 0; t < 16 && rds.size() == 16; t++) begin
      exp_a = (((t / 4) % 2 == 0) ? 32'h1000 : 32'h2000) + 32'(16 * (t / 8)) + 32'(4 * (t % 4));
      checks++; if (rds[t] !== exp_a) begin errors++; $display("FAIL rr_order%0d: got %h want %h", t, rds[t], exp_a); end
    end
    checks++; if (breq_rise - b0 !== 4) begin errors++; $display("FAIL rr_tenures: got %0d Bus_Req rises want 4", breq_rise - b0); end
    checks++; if (irq_status !== 4'b0110) begin errors++; $display("FAIL rr_irq: got %b want 0110", irq_status); end
  endtask
  task automatic test_zero_count();
    int n0 = nonseq_cnt;
    int a3 = ack_cnt[3];
    int first = -1;
    cfg(3, 2, 32'd0); cfg(3, 3, 32'd1);
    req[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (ack[3] && first < 0) first = k;
    end
    req[3] = 1'b0;
    checks++; if (first !== 2) begin errors++; $display("FAIL zero_ack_latency: got %0d cycles want 2", first); end
    checks++; if (nonseq_cnt - n0 !== 0) begin errors++; $display("FAIL zero_no_bus: got %0d NONSEQ cycles want 0", nonseq_cnt - n0); end
    checks++; if (ack_cnt[3] - a3 !== 1) begin errors++; $display("FAIL zero_ack_count: got %0d want 1", ack_cnt[3] - a3); end
    checks++; if (irq_status[3] !== 1'b1) begin errors++; $display("FAIL zero_irq: got %b want 1", irq_status[3]); end
  endtask
  task automatic test_stall_fixed_dst();
    bit got = 0;
    alog.delete(); wlog.delete();
    stall_rd = 3;
    cfg(0, 0, 32'h500); cfg(0, 1, 32'h600); cfg(0, 2, 32'd2); cfg(0, 3, 32'd3);
    req[0] = 1'b1;
    for (int t = 0; t < 500 && !got; t++) begin
      @(posedge clk); #1;
      if (ack[0]) begin got = 1; irq_clr = 4'b0001; end
    end
    @(posedge clk); #1;
    irq_clr = 4'b0000;
    req[0] = 1'b0;
    stall_rd = 0;
    checks++; if (!got) begin errors++; $display("FAIL stall_done: ReqAck[0] not seen, want pulse"); end
    checks++; if (irq_status[0] !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got irq_status[0]=%b want 1", irq_status[0]); end
    checks++; if (alog.size() !== 4) begin errors++; $display("FAIL stall_addr_count: got %0d want 4", alog.size()); end
    if (alog.size() == 4) begin
      checks++; if (alog[1] !== {1'b1, 32'h600}) begin errors++; $display("FAIL stall_wr0: got %h want %h", alog[1], {1'b1, 32'h600}); end
      checks++; if (alog[2] !== {1'b0, 32'h504}) begin errors++; $display("FAIL stall_rd1: got %h want %h", alog[2], {1'b0, 32'h504}); end
      checks++; if (alog[3] !== {1'b1, 32'h600}) begin errors++; $display("FAIL stall_wr1: got %h want %h", alog[3], {1'b1, 32'h600}); end
    end
    checks++; if (wlog.size() !== 2) begin errors++; $display("FAIL stall_wdata_count: got %0d want 2", wlog.size()); end
    if (wlog.size() == 2) begin
      checks++; if (wlog[0] !== (32'h500 ^ K)) begin errors++; $display("FAIL stall_wdata0: got %h want %h", wlog[0], 32'h500 ^ K); end
      checks++; if (wlog[1] !== (32'h504 ^ K)) begin errors++; $display("FAIL stall_wdata1: got %h want %h", wlog[1], 32'h504 ^ K); end
    end
  endtask
  task automatic test_reset_mid();
    bit found = 0;
    cfg(0, 0, 32'h700); cfg(0, 1, 32'h800); cfg(0, 2, 32'd1); cfg(0, 3, 32'd7);
    req[0] = 1'b1;
    for (int t = 0; t < 100 && !found; t++) begin
      @(posedge clk); #1;
      if (bus.MTrans == 2'b10 && bus.MWrite) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach: write address phase not seen"); end
    rst = 1'b1;
    #1;
    checks++; if (bus.Bus_Req !== 1'b0) begin errors++; $display("FAIL rst_mid_bus_req: got %b want 0", bus.Bus_Req); end
    checks++; if (bus.MTrans !== 2'b00) begin errors++; $display("FAIL rst_mid_mtrans: got %b want 00", bus.MTrans); end
    checks++; if (bus.MWrite !== 1'b0) begin errors++; $display("FAIL rst_mid_mwrite: got %b want 0", bus.MWrite); end
    checks++; if (bus.MAddress !== 32'h0) begin errors++; $display("FAIL rst_mid_maddress: got %h want 0", bus.MAddress); end
    checks++; if (irq_status !== 4'h0) begin errors++; $display("FAIL rst_mid_irq: got %b want 0000", irq_status); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_mid_interrupt: got %b want 0", intr); end
    req = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
`ifdef DMAC_ERR_ABORT_EN
  task automatic test_err_abort();
    bit ok;
    int n0;
    int rd = 0, wr = 0;
    alog.delete();
    cfg(0, 0, 32'h900); cfg(0, 1, 32'hA00); cfg(0, 2, 32'd4); cfg(0, 3, 32'd7);
    err_at = rd_num + 2;
    req[0] = 1'b1;
    wait_ack(0, ack_cnt[0] + 1, ok);
    n0 = nonseq_cnt;
    repeat (10) @(posedge clk);
    #1;
    foreach (alog[i]) if (alog[i][32]) wr++; else rd++;
    checks++; if (!ok) begin errors++; $display("FAIL err_ack: ReqAck[0] not seen, want pulse"); end
    checks++; if (err_status !== 4'b0001) begin errors++; $display("FAIL err_status: got %b want 0001", err_status); end
    checks++; if (irq_status[0] !== 1'b1) begin errors++; $display("FAIL err_irq: got %b want 1", irq_status[0]); end
    checks++; if (dut.cnt[0] !== 16'd3) begin errors++; $display("FAIL err_count_frozen: got %0d want 3", dut.cnt[0]); end
    checks++; if (dut.ctrl[0][0] !== 1'b0) begin errors++; $display("FAIL err_enable: got %b want 0", dut.ctrl[0][0]); end
    checks++; if (rd !== 2 || wr !== 1) begin errors++; $display("FAIL err_bus_cycles: got rd=%0d wr=%0d want rd=2 wr=1", rd, wr); end
    checks++; if (nonseq_cnt - n0 !== 0) begin errors++; $display("FAIL err_quiet: got %0d NONSEQ cycles after abort want 0", nonseq_cnt - n0); end
    req[0] = 1'b0;
    err_at = -1;
    irq_clr = 4'hF;
    @(posedge clk); #1;
    irq_clr = 4'h0;
    checks++; if (err_status !== 4'b0000) begin errors++; $display("FAIL err_clear: got %b want 0000", err_status); end
  endtask
`endif
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_count();
    test_stall_fixed_dst();
    test_reset_mid();
`ifdef DMAC_ERR_ABORT_EN
    test_err_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmac_multi_channel.md
Name: dmac_multi_channel

Overview:
- Parametrised N-channel successor to the two-channel DMAC top. Single AHB-lite master engine, shared by NCH channels.
- Each channel has source, destination, count and control registers, loaded through a simple config port.
- A round-robin arbiter picks among requesting enabled channels. Each element moves as one word: single read, then single write, through an internal data register.
- Sits between the peripheral request lines, the system bus arbiter and the AHB-lite fabric.

Parameters:
- NCH, 4, number of channels (2..8).
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width (word transfers only).
- CNT_W, 16, per-channel element-count width.
- BEATS_PER_GRANT, 4, maximum elements moved per bus tenure before re-arbitration (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- DmacReq  in  NCH  per-channel peripheral request, level
- ReqAck  out  NCH  one-cycle pulse on channel completion
- Bus_Req  out  1  request to system bus arbiter
- Bus_Grant  in  1  grant from arbiter
- MAddress  out  ADDR_W  AHB HADDR
- MWData  out  DATA_W  AHB HWDATA
- MRData  in  DATA_W  AHB HRDATA
- MWrite  out  1  AHB HWRITE
- MTrans  out  2  AHB HTRANS (IDLE=00, NONSEQ=10 only)
- MWStrb  out  DATA_W/8  write strobes, all ones during write data phase, else 0
- HReady  in  1  AHB HREADY
- M_HResp  in  2  AHB HRESP (00 OKAY, 01 ERROR)
- cfg_we  in  1  config write strobe
- cfg_ch  in  $clog2(NCH)  target channel
- cfg_sel  in  2  0=SRC, 1=DST, 2=COUNT, 3=CTRL{bit0 enable, bit1 src_inc, bit2 dst_inc}
- cfg_wdata  in  ADDR_W  write data
- irq_clr  in  NCH  write-one-to-clear for irq_status
- irq_status  out  NCH  sticky per-channel done flags
- Interrupt  out  1  OR of irq_status

Behaviour:
- Reset: all channel registers 0, irq_status 0, FSM IDLE, rr pointer 0. All outputs 0; MTrans=00.
- FSM states and transitions:
  - IDLE -> ARB when any (DmacReq[i] & enable[i]).
  - ARB picks the first eligible channel after the last-served index, wrapping around. It latches the channel and clears beat_cnt. If the chosen count==0: no bus access; go to DONE.
  - BUSREQ: Bus_Req=1; on Bus_Grant -> RD_ADDR.
  - RD_ADDR: MTrans=10, MWrite=0, MAddress=src; on HReady -> RD_DATA.
  - RD_DATA: MTrans=00; on HReady, capture MRData into data reg -> WR_ADDR.
  - WR_ADDR: MTrans=10, MWrite=1, MAddress=dst; on HReady -> WR_DATA.
  - WR_DATA: MWData=data reg, MWStrb all ones; on HReady -> NEXT.
  - NEXT: count-=1; src+=DATA_W/8 if src_inc; dst+=DATA_W/8 if dst_inc; beat_cnt+=1.
    - New count==0 -> DONE.
    - Else if beat_cnt==BEATS_PER_GRANT or DmacReq[ch]==0 -> IDLE (Bus_Req drops).
    - Else -> RD_ADDR.
  - DONE: clear enable[ch], set irq_status[ch], pulse ReqAck[ch] for 1 cycle -> IDLE.
- Bus_Req is held from BUSREQ through NEXT. The arbiter guarantees Bus_Grant holds while Bus_Req=1.
- Minimum latency per element: 4 cycles with zero-wait HReady, plus 1 NEXT cycle.
- Address increment wraps modulo 2^ADDR_W. COUNT is truncated to CNT_W bits.
- cfg_we to the currently active channel (ARB..DONE) is ignored. Writes to other channels take effect next cycle.
- irq_clr and a DONE set on the same bit in the same cycle: set wins.
- A request that deasserts mid-element does not abort the element; the check happens only in NEXT.

Optional Feature:
- Macro: DMAC_ERR_ABORT_EN.
- Defined: M_HResp==01 seen in RD_DATA or WR_DATA aborts the channel.
  - Clears enable, sets err_status[ch] (extra output NCH, sticky, cleared by irq_clr), pulses ReqAck, sets irq_status, goes to IDLE.
  - Count and addresses are frozen at the failing element.
- Undefined: HRESP is ignored and the transfer continues; no err_status port.

Decomposition:
- Package dmac_multi_pkg: state enum (IDLE, ARB, BUSREQ, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, NEXT, DONE), HTRANS constants, cfg_sel encodings, ctrl bit positions.
- Sub-module dmac_rr_arbiter: parametrised NCH round-robin picker (req vector, last index -> grant index, valid).

Test Plan:
- Ch0 src=0x100, dst=0x200, count=3, inc both, req held, zero-wait bus -> reads 0x100/0x104/0x108, writes 0x200/0x204/0x208. ReqAck[0] one pulse, irq_status=0001, Interrupt=1.
- Ch1 and ch2 both requesting, count=8, BEATS_PER_GRANT=4 -> element order ch1 x4, ch2 x4, ch1 x4, ch2 x4; Bus_Req drops between tenures.
- Ch3 count=0, enable, req -> no MTrans=10 cycles; ReqAck[3] pulses 2 cycles after request.
- dst_inc=0, count=2, HReady low 3 cycles in RD_DATA -> both writes to the same dst; MRData captured only when HReady=1.
- irq_clr[0] in the same cycle as ch0 DONE -> irq_status[0]=1. rst asserted in WR_ADDR -> all outputs 0 the same cycle.
- DMAC_ERR_ABORT_EN: M_HResp=01 on 2nd read of count=4 -> err_status[ch]=1, count register=3, enable=0, no further bus cycles.
